// File: rtl/alu_cmd_sequencer.sv
// Collects opcode/A/B words from a byte stream, drives stable operands into the ALU,
// waits a fixed latency, then returns the captured result/status on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int N   = 2,
  parameter int M   = 8,
  parameter int LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [M-1:0] i_in_data,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic [N-1:0] o_alu_op,
  output logic [M-1:0] o_alu_arg_A,
  output logic [M-1:0] o_alu_arg_B,
  input  logic [M-1:0] i_alu_result,
  input  logic [3:0]   i_alu_status,
  output logic [M-1:0] o_out_result,
  output logic [3:0]   o_out_status,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_busy,
  output logic         o_err,
  output logic [7:0]   o_done_cnt,
  output logic [2:0]   o_dbg_state
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    ISSUE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic           in_xfer;
  logic           bad_op;
  logic [N-1:0]   op_hold;
  logic [M-1:0]   a_hold;
  logic [CW-1:0]  wait_cnt;

  // Handshakes: a word moves on a rising edge where i_in_valid && o_in_ready; a response
  // moves on a rising edge where o_out_valid && i_out_ready. Valid never drops before that edge.
  assign in_xfer = i_in_valid & o_in_ready;
  assign bad_op  = |i_in_data[M-1:N];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_in_ready  = (state == IDLE) || (state == GET_A) || (state == GET_B);
    o_busy      = (state != IDLE);
    o_dbg_state = state;
    unique case (state)
      IDLE:    if (in_xfer && !bad_op) state_nxt = GET_A;
      GET_A:   if (in_xfer) state_nxt = GET_B;
      GET_B:   if (in_xfer) state_nxt = ISSUE;
      ISSUE:   if (wait_cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (i_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      op_hold      <= '0;
      a_hold       <= '0;
      wait_cnt     <= '0;
      o_alu_op     <= '0;
      o_alu_arg_A  <= '0;
      o_alu_arg_B  <= '0;
      o_out_result <= '0;
      o_out_status <= '0;
      o_out_valid  <= 1'b0;
      o_err        <= 1'b0;
      o_done_cnt   <= '0;
    end else begin
      o_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_xfer) begin
            if (bad_op) o_err   <= 1'b1;
            else        op_hold <= i_in_data[N-1:0];
          end
        end
        GET_A: if (in_xfer) a_hold <= i_in_data;
        GET_B: begin
          // ALU-facing operands only ever change here, so they stay stable through the wait.
          if (in_xfer) begin
            o_alu_op    <= op_hold;
            o_alu_arg_A <= a_hold;
            o_alu_arg_B <= i_in_data;
            wait_cnt    <= CW'(LAT);
          end
        end
        ISSUE: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) begin
            o_out_result <= i_alu_result;
            o_out_status <= i_alu_status;
            o_out_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_done_cnt  <= o_done_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: LAT=1 instance with a combinational ALU stub, plus a
// LAT=3 instance whose stub output is a free-running cycle count to pin capture timing.
module tb_alu_cmd_sequencer;

  logic       i_clk;
  logic       i_reset;

  // LAT=1 instance
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_result;
  logic [3:0] alu_status;
  logic [11:0] alu_rs;
  logic [7:0] out_result;
  logic [3:0] out_status;
  logic       out_valid;
  logic       out_ready;
  logic       busy, err;
  logic [7:0] done_cnt;
  logic [2:0] dbg_state;

  // LAT=3 instance
  logic [7:0] in_data3;
  logic       in_valid3;
  logic       in_ready3;
  logic [1:0] alu_op3;
  logic [7:0] alu_a3, alu_b3;
  logic [7:0] out_result3;
  logic [3:0] out_status3;
  logic       out_valid3;
  logic       out_ready3;
  logic       busy3, err3;
  logic [7:0] done_cnt3;
  logic [2:0] dbg_state3;
  logic [7:0] tb_cyc;

  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_done;
  logic [11:0] exp_q[$];

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GETA = 3'd1;
  localparam logic [2:0] S_RESP = 3'd4;

  alu_cmd_sequencer #(.N(2), .M(8), .LAT(1)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_alu_op(alu_op), .o_alu_arg_A(alu_a), .o_alu_arg_B(alu_b),
    .i_alu_result(alu_result), .i_alu_status(alu_status),
    .o_out_result(out_result), .o_out_status(out_status),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy), .o_err(err), .o_done_cnt(done_cnt), .o_dbg_state(dbg_state)
  );

  alu_cmd_sequencer #(.N(2), .M(8), .LAT(3)) u_dut3 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_in_data(in_data3), .i_in_valid(in_valid3), .o_in_ready(in_ready3),
    .o_alu_op(alu_op3), .o_alu_arg_A(alu_a3), .o_alu_arg_B(alu_b3),
    .i_alu_result(tb_cyc), .i_alu_status(tb_cyc[3:0]),
    .o_out_result(out_result3), .o_out_status(out_status3),
    .o_out_valid(out_valid3), .i_out_ready(out_ready3),
    .o_busy(busy3), .o_err(err3), .o_done_cnt(done_cnt3), .o_dbg_state(dbg_state3)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) tb_cyc <= 8'd0;
    else          tb_cyc <= tb_cyc + 8'd1;
  end

  // ---------------- ALU stub and reference ----------------
  function automatic logic [11:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [7:0] r;
    case (op)
      2'd0:    r = a - b - 8'd3;
      2'd1:    r = a + b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return {r, r[7], (r == 8'd0), op ^ 2'b01};
  endfunction

  assign alu_rs     = alu_model(alu_op, alu_a, alu_b);
  assign alu_result = alu_rs[11:4];
  assign alu_status = alu_rs[3:0];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    exp_done = 8'd0;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    int g;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge i_clk);
      #1;
    end
    in_data  = w;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    if (g >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge i_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_compare(input string name);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_result"}, {24'd0, out_result}, {24'd0, e[11:4]});
      check({name, "_status"}, {28'd0, out_status}, {28'd0, e[3:0]});
    end
  endtask

  // Full command on the LAT=1 instance; ends #1 after the response accept edge.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int gap, input logic [11:0] exp_rs, input int resp_delay);
    int g;
    exp_q.push_back(exp_rs);
    send_word(op, gap);
    send_word(a, gap);
    send_word(b, gap);
    check("alu_op", {30'd0, alu_op}, {30'd0, op[1:0]});
    check("alu_a", {24'd0, alu_a}, {24'd0, a});
    check("alu_b", {24'd0, alu_b}, {24'd0, b});
    check("valid_low_after_b", {31'd0, out_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    check("valid_lat1", {31'd0, out_valid}, 32'd1);
    g = 0;
    while (!out_valid && g < 20) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    repeat (resp_delay) begin
      @(posedge i_clk);
      #1;
      check("valid_held", {31'd0, out_valid}, 32'd1);
    end
    pop_compare("resp");
    out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    out_ready = 1'b0;
    exp_done  = exp_done + 8'd1;
    check("valid_cleared", {31'd0, out_valid}, 32'd0);
    check("done_cnt", {24'd0, done_cnt}, {24'd0, exp_done});
    check("idle_after_accept", {29'd0, dbg_state}, {29'd0, S_IDLE});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    logic [7:0] exp_r;
    logic [3:0] exp_s;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time 0x%0h expected below 0xf4240", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    logic [7:0] ro, ra, rb;
    logic [11:0] hold_rs;
    n_checks  = 0;
    n_fail    = 0;
    exp_done  = 8'd0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data3  = 8'd0;
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;

    vecs[0] = '{8'h00, 8'h10, 8'h03, 0, 8'h0A, 4'b0001};
    vecs[1] = '{8'h01, 8'h80, 8'h7F, 0, 8'hFF, 4'b1000};
    vecs[2] = '{8'h02, 8'hF0, 8'h3C, 1, 8'h30, 4'b0011};
    vecs[3] = '{8'h03, 8'h00, 8'h00, 2, 8'h00, 4'b0110};
    vecs[4] = '{8'h00, 8'h05, 8'h02, 3, 8'h00, 4'b0101};
    vecs[5] = '{8'h01, 8'hC8, 8'h64, 1, 8'h2C, 4'b0000};
    vecs[6] = '{8'h03, 8'h81, 8'h02, 0, 8'h83, 4'b1010};

    apply_reset();

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("rst_outputs", {alu_op, alu_a, alu_b, out_result}, 32'd0);
    check("rst_flags", {out_status, out_valid, err, done_cnt}, 32'd0);

    // Table-driven commands
    for (int i = 0; i < 7; i++)
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].gap,
              {vecs[i].exp_r, vecs[i].exp_s}, i % 3);

    // Malformed opcode: dropped, one-cycle error pulse
    send_word(8'h05, 0);
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_state_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("err_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    check("err_one_cycle", {31'd0, err}, 32'd0);
    run_cmd(8'h01, 8'h80, 8'h7F, 0, {8'hFF, 4'b1000}, 0);

    // Output backpressure with producer pushing words during RESP
    hold_rs = alu_model(2'd2, 8'h33, 8'h0F);
    exp_q.push_back(hold_rs);
    send_word(8'h02, 0);
    send_word(8'h33, 0);
    send_word(8'h0F, 0);
    @(posedge i_clk);
    #1;
    in_data  = 8'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", {20'd0, out_result, out_status}, {20'd0, hold_rs});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_state", {29'd0, dbg_state}, {29'd0, S_RESP});
    end
    in_valid = 1'b0;
    pop_compare("bp");
    out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    out_ready = 1'b0;
    exp_done  = exp_done + 8'd1;
    check("bp_accept_valid", {31'd0, out_valid}, 32'd0);
    check("bp_accept_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("bp_done_cnt", {24'd0, done_cnt}, {24'd0, exp_done});

    // Latency sweep on the LAT=3 instance
    in_valid3 = 1'b1;
    in_data3  = 8'h02;
    @(posedge i_clk);
    #1;
    in_data3 = 8'h5A;
    @(posedge i_clk);
    #1;
    in_data3 = 8'hC3;
    @(posedge i_clk);
    #1;
    in_valid3 = 1'b0;
    c = tb_cyc + 8'd2;
    check("lat3_alu_regs", {14'd0, alu_op3, alu_a3, alu_b3}, {14'd0, 2'd2, 8'h5A, 8'hC3});
    @(posedge i_clk);
    #1;
    check("lat3_valid_k1", {31'd0, out_valid3}, 32'd0);
    @(posedge i_clk);
    #1;
    check("lat3_valid_k2", {31'd0, out_valid3}, 32'd0);
    @(posedge i_clk);
    #1;
    check("lat3_valid_k3", {31'd0, out_valid3}, 32'd1);
    check("lat3_result", {24'd0, out_result3}, {24'd0, c});
    check("lat3_status", {28'd0, out_status3}, {28'd0, c[3:0]});
    out_ready3 = 1'b1;
    @(posedge i_clk);
    #1;
    out_ready3 = 1'b0;
    check("lat3_done", {23'd0, out_valid3, done_cnt3}, {23'd0, 1'b0, 8'd1});

    // Asynchronous reset during ISSUE
    send_word(8'h03, 0);
    send_word(8'hFF, 0);
    send_word(8'h01, 0);
    #2;
    i_reset = 1'b0;
    #1;
    check("arst_alu", {alu_op, alu_a, alu_b, out_result}, 32'd0);
    check("arst_flags", {out_status, out_valid, err, done_cnt}, 32'd0);
    check("arst_ready_busy", {30'd0, in_ready, busy}, 32'd2);
    check("arst_lat3_cnt", {24'd0, done_cnt3}, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset  = 1'b1;
    exp_done = 8'd0;
    exp_q.delete();
    run_cmd(8'h00, 8'h10, 8'h03, 0, {8'h0A, 4'b0001}, 0);
    send_word(8'h02, 0);
    check("partial_cmd_geta", {29'd0, dbg_state}, {29'd0, S_GETA});

    // Counter wrap over 256 randomised commands, with gaps
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      ro = 8'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_cmd(ro, ra, rb, $urandom_range(0, 3), alu_model(ro[1:0], ra, rb),
              $urandom_range(0, 2));
    end
    check("wrap_done_zero", {24'd0, done_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
